// File: rtl/sample_ingest_if.sv
// Sample ingest bus: external strobe/sample in, FWFT FIFO head and status out.
interface sample_ingest_if #(
    parameter int BITS_PER_ELEM = 8,
    parameter int FIFO_DEPTH    = 4
);
    logic                           i_data_clk;
    logic [BITS_PER_ELEM-1:0]       i_value;
    logic                           i_ready;
    logic [BITS_PER_ELEM-1:0]       o_value;
    logic                           o_valid;
    logic [$clog2(FIFO_DEPTH):0]    o_level;
    logic                           o_overflow;
    logic [7:0]                     o_drop_count;

    // The ingest block itself.
    modport slave (
        input  i_data_clk, i_value, i_ready,
        output o_value, o_valid, o_level, o_overflow, o_drop_count
    );

    // Whoever drives the strobe and consumes the FIFO head.
    modport master (
        output i_data_clk, i_value, i_ready,
        input  o_value, o_valid, o_level, o_overflow, o_drop_count
    );
endinterface

// File: rtl/sample_ingest.sv
// Sample ingest: synchronizes an asynchronous sample strobe into clk, pushes
// one sample per strobe rise into a small first-word fall-through FIFO, and
// tracks dropped samples when the FIFO is full.
module sample_ingest #(
    parameter int BITS_PER_ELEM = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    sample_ingest_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    // Strobe synchronizer, history flop and matching sample pipeline.
    logic                     s1, s2, s3;
    logic [BITS_PER_ELEM-1:0] v1, v2;
    // sync_ok[1] marks that s2 carries a real post-reset sample; armed is set
    // once that sample has been seen low, so a level already high across
    // reset never turns into a push.
    logic [1:0]               sync_ok;
    logic                     armed;

    logic [BITS_PER_ELEM-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [LW-1:0]            level;
    logic                     valid;
    logic                     overflow;
    logic [7:0]               drop_count;

    logic rise, push, pop, full, accept, drop;

    assign rise   = s2 & ~s3;
    assign push   = rise & armed;
    assign pop    = valid & bus.i_ready;
    assign full   = (level == FULL_LEVEL);
    // When full, a same-edge pop frees the slot the push needs.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // Synchronize the strobe, align the sample with it, and arm edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            v1      <= '0;
            v2      <= '0;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            s1      <= bus.i_data_clk;
            s2      <= s1;
            s3      <= s2;
            v1      <= bus.i_value;
            v2      <= v1;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & ~s2);
        end
    end

    // Sample storage; contents are not cleared by reset, pointers decide what is live.
    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem[wr_ptr] <= v2;
    end

    // Pointers, occupancy and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10: begin
                    level <= level + LW'(1);
                    valid <= 1'b1;
                end
                2'b01: begin
                    level <= level - LW'(1);
                    valid <= (level != LW'(1));
                end
                default: ;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign bus.o_value      = mem[rd_ptr];
    assign bus.o_valid      = valid;
    assign bus.o_level      = level;
    assign bus.o_overflow   = overflow;
    assign bus.o_drop_count = drop_count;
endmodule

// File: tb/tb_sample_ingest.sv
// Directed bench for sample_ingest: latency, fill/drain, overflow, full
// push+pop, held strobe level, drop saturation and mid-stream reset.
module tb_sample_ingest;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    sample_ingest_if #(.BITS_PER_ELEM(8), .FIFO_DEPTH(4)) bus();

    sample_ingest #(.BITS_PER_ELEM(8), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    // One strobe: rise held 3 cycles (push lands on the 3rd edge), then low 3 cycles.
    task automatic strobe(input logic [7:0] val);
        bus.i_value    = val;
        bus.i_data_clk = 1'b1;
        repeat (3) tick();
        bus.i_data_clk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        bus.i_data_clk = 1'b0;
        bus.i_value    = 8'h00;
        bus.i_ready    = 1'b0;
        do_reset();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bus.o_valid); end
        checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.o_level); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b want=0", bus.o_overflow); end
        checks++; if (bus.o_drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops got=%0d want=0", bus.o_drop_count); end
    endtask

    task automatic test_single();
        bus.i_value    = 8'h5A;
        bus.i_data_clk = 1'b1;
        repeat (2) tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0b want=0", bus.o_valid); end
        tick();
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", bus.o_valid); end
        checks++; if (bus.o_value !== 8'h5A) begin errors++; $display("FAIL single_value got=%h want=5a", bus.o_value); end
        checks++; if (bus.o_level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d want=1", bus.o_level); end
        bus.i_data_clk = 1'b0;
        repeat (3) tick();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b want=0", bus.o_valid); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) strobe(8'(i));
        checks++; if (bus.o_level !== 3'd4) begin errors++; $display("FAIL fill_level got=%0d want=4", bus.o_level); end
        bus.i_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.o_value !== 8'(i)) begin errors++; $display("FAIL drain_order[%0d] got=%h want=%h", i, bus.o_value, 8'(i)); end
            tick();
        end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b want=0", bus.o_valid); end
        // Ready while empty: nothing moves, no underflow.
        repeat (3) tick();
        checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL empty_ready_level got=%0d want=0", bus.o_level); end
        bus.i_ready = 1'b0;
        strobe(8'hC3);
        checks++; if (bus.o_value !== 8'hC3 || bus.o_level !== 3'd1) begin errors++; $display("FAIL empty_ready_next got=%h/%0d want=c3/1", bus.o_value, bus.o_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i));
        checks++; if (bus.o_level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d want=4", bus.o_level); end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b want=1", bus.o_overflow); end
        checks++; if (bus.o_drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drops got=%0d want=2", bus.o_drop_count); end
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.o_value !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, bus.o_value, 8'h10 + 8'(i)); end
            tick();
        end
        bus.i_ready = 1'b0;
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b want=1", bus.o_overflow); end
    endtask

    task automatic test_push_pop();
        // Non-full: level unchanged across a same-edge push and pop.
        do_reset();
        strobe(8'h30);
        strobe(8'h31);
        bus.i_value    = 8'h32;
        bus.i_data_clk = 1'b1;
        repeat (2) tick();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        checks++; if (bus.o_level !== 3'd2 || bus.o_value !== 8'h31) begin errors++; $display("FAIL pp_half got=%0d/%h want=2/31", bus.o_level, bus.o_value); end
        bus.i_data_clk = 1'b0;
        repeat (3) tick();
        // Full: pop frees the slot, push accepted, no drop.
        do_reset();
        for (int i = 0; i < 4; i++) strobe(8'h20 + 8'(i));
        bus.i_value    = 8'h24;
        bus.i_data_clk = 1'b1;
        repeat (2) tick();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        checks++; if (bus.o_level !== 3'd4) begin errors++; $display("FAIL pp_full_level got=%0d want=4", bus.o_level); end
        checks++; if (bus.o_drop_count !== 8'd0 || bus.o_overflow !== 1'b0) begin errors++; $display("FAIL pp_full_drop got=%0d/%0b want=0/0", bus.o_drop_count, bus.o_overflow); end
        bus.i_data_clk = 1'b0;
        repeat (3) tick();
        bus.i_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.o_value !== 8'h20 + 8'(i)) begin errors++; $display("FAIL pp_order[%0d] got=%h want=%h", i, bus.o_value, 8'h20 + 8'(i)); end
            tick();
        end
        bus.i_ready = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got=%0b want=0", bus.o_valid); end
    endtask

    task automatic test_level_and_saturation();
        do_reset();
        bus.i_value    = 8'h40;
        bus.i_data_clk = 1'b1;
        repeat (20) tick();
        checks++; if (bus.o_level !== 3'd1) begin errors++; $display("FAIL held_level got=%0d want=1", bus.o_level); end
        bus.i_data_clk = 1'b0;
        repeat (3) tick();
        for (int i = 1; i <= 3; i++) strobe(8'h40 + 8'(i));
        for (int i = 0; i < 300; i++) strobe(8'hEE);
        checks++; if (bus.o_drop_count !== 8'd255) begin errors++; $display("FAIL sat_drops got=%0d want=255", bus.o_drop_count); end
        checks++; if (bus.o_level !== 3'd4 || bus.o_value !== 8'h40) begin errors++; $display("FAIL sat_contents got=%0d/%h want=4/40", bus.o_level, bus.o_value); end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL sat_flag got=%0b want=1", bus.o_overflow); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) strobe(8'h50 + 8'(i));
        checks++; if (bus.o_level !== 3'd3) begin errors++; $display("FAIL mid_pre_level got=%0d want=3", bus.o_level); end
        bus.i_value    = 8'h66;
        bus.i_data_clk = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_level !== 3'd0) begin errors++; $display("FAIL mid_cleared got=%0b/%0d want=0/0", bus.o_valid, bus.o_level); end
        checks++; if (bus.o_overflow !== 1'b0 || bus.o_drop_count !== 8'd0) begin errors++; $display("FAIL mid_status got=%0b/%0d want=0/0", bus.o_overflow, bus.o_drop_count); end
        repeat (10) tick();
        checks++; if (bus.o_level !== 3'd0) begin errors++; $display("FAIL mid_held_nopush got=%0d want=0", bus.o_level); end
        bus.i_data_clk = 1'b0;
        repeat (3) tick();
        strobe(8'h77);
        checks++; if (bus.o_level !== 3'd1 || bus.o_value !== 8'h77) begin errors++; $display("FAIL mid_repush got=%0d/%h want=1/77", bus.o_level, bus.o_value); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_push_pop();
        test_level_and_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
